encrypt_ctrl: RTL and testbench

Iterative AES-128/192/256 encryption engine, one round per clock. It is the forward-direction counterpart of the decrypt path and shares the same 2-bit key-size `switch` encoding and packed 1920-bit round-key bus. A valid/ready handshake on input and output lets the top-level sequencer queue blocks without counting cycles. Key expansion happens upstream; this block only consumes the expanded schedule.

---
 rtl/encrypt_ctrl.sv | 175 +++++++++++++++++
 tb/tb_encrypt_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_ctrl.sv
// Iterative AES-128/192/256 encryption core: one round per clock, valid/ready on both sides.
// Consumes a pre-expanded round-key schedule; key size selected per block by switch.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ m;
            m = xt(m);
        end
        return p;
    endfunction

    logic [7:0] a2, a3, a12, a15, a240, inv;

    // Multiplicative inverse as a^254 (zero maps to zero), then the affine transform
    always_comb begin
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a12  = gmul(gmul(a3, a3), gmul(a3, a3));
        a15  = gmul(a12, a3);
        a240 = gmul(a15, a15);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        inv  = gmul(gmul(a240, a12), a2);
        s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module encrypt_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [127:0]  in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1919:0] key_e,
    input  logic [1:0]    switch,
    output logic [127:0]  out,
    output logic          out_valid,
    input  logic          out_ready
);
    localparam int unsigned NB = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm, fsm_nxt;
    logic [127:0] state;
    logic [3:0]   round;
    logic [3:0]   nr;
    logic [3:0]   nr_sel;
    logic         accept, advance, finish, release_c;

    logic [7:0]   sb [NB];
    logic [7:0]   sr [NB];
    logic [7:0]   mc [NB];
    logic [127:0] sr_w, mc_w, rk, round_res;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar k = 0; k < 16; k++) begin : g_sbox
        aes_sbox u_sbox (
            .a (state[127-8*k -: 8]),
            .s (sb[k])
        );
    end

    // ShiftRows, MixColumns and AddRoundKey for the current round
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xt(sr[4*c+0]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xt(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
        end
        sr_w = '0;
        mc_w = '0;
        for (int k = 0; k < 16; k++) begin
            sr_w[127-8*k -: 8] = sr[k];
            mc_w[127-8*k -: 8] = mc[k];
        end
        rk        = key_e[{round, 7'd0} +: 128];
        round_res = ((round == nr) ? sr_w : mc_w) ^ rk;
    end

    always_comb begin
        case (switch)
            2'b00:   nr_sel = 4'd10;
            2'b01:   nr_sel = 4'd12;
            default: nr_sel = 4'd14;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt   = fsm;
        accept    = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        release_c = 1'b0;
        case (fsm)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    fsm_nxt = RUN;
                end
            end
            RUN: begin
                if (round == nr) begin
                    finish  = 1'b1;
                    fsm_nxt = DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_c = 1'b1;
                    fsm_nxt   = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    assign in_ready = (fsm == IDLE);

    // Round datapath and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= '0;
            round     <= '0;
            nr        <= 4'd10;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                state <= in ^ key_e[127:0];
                nr    <= nr_sel;
                round <= 4'd1;
            end else if (advance) begin
                state <= round_res;
                round <= round + 4'd1;
            end
            if (finish) begin
                out       <= round_res;
                out_valid <= 1'b1;
            end else if (release_c) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_encrypt_ctrl.sv
// Directed bench for encrypt_ctrl: FIPS-197 vectors, back-pressure, mid-run input change, reset mid-run.
// Round keys are expanded here from a table-driven key schedule; expected ciphertexts go through a queue.

module tb_encrypt_ctrl;
    logic          clk = 1'b0;
    logic          rst_n;
    logic [127:0]  in;
    logic          in_valid;
    logic          in_ready;
    logic [1919:0] key_e;
    logic [1:0]    switch;
    logic [127:0]  out;
    logic          out_valid;
    logic          out_ready;

    int n_assert = 0;
    int n_fail   = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sbox_tab [256];

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    encrypt_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_e     (key_e),
        .switch    (switch),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtb(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ke;
        int nrr, total;
        nrr   = nk + 6;
        total = 4 * (nrr + 1);
        rc    = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtb(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        ke = '0;
        for (int r = 0; r <= nrr; r++) ke[128*r+127 -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ke;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic accept(input logic [127:0] pt, input logic [255:0] key, input int nk,
                          input logic [1:0] sw, input logic [127:0] ct);
        @(negedge clk);
        in       = pt;
        key_e    = expand(key, nk);
        switch   = sw;
        in_valid = 1'b1;
        check("in_ready_before_accept", 128'(in_ready), 128'd1);
        exp_q.push_back(ct);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int lat;
        logic [127:0] expv;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_ct"}, out, expv);
    endtask

    task automatic back_to_idle(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_in_ready_after"}, 128'(in_ready), 128'd1);
        check({tag, "_out_valid_after"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        logic [2047:0] tab;
        logic [127:0]  held;
        tab = SBOX_HEX;
        for (int i = 0; i < 256; i++) sbox_tab[i] = tab[2047-8*i -: 8];

        rst_n     = 1'b0;
        in        = '0;
        in_valid  = 1'b0;
        key_e     = '0;
        switch    = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_out", out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 128'(in_ready), 128'd1);

        accept(PT_B, KEY_B, 4, 2'b00, CT_B);
        wait_out("appB", 10);
        back_to_idle("appB");

        accept(PT_C, {KEY_C[255:128], 128'h0}, 4, 2'b00, CT_C128);
        wait_out("appC128", 10);
        back_to_idle("appC128");

        accept(PT_C, {KEY_C[255:64], 64'h0}, 6, 2'b01, CT_C192);
        wait_out("appC192", 12);
        back_to_idle("appC192");

        accept(PT_C, KEY_C, 8, 2'b10, CT_C256);
        wait_out("appC256_sw10", 14);
        back_to_idle("appC256_sw10");

        accept(PT_C, KEY_C, 8, 2'b11, CT_C256);
        wait_out("appC256_sw11", 14);
        back_to_idle("appC256_sw11");

        // Back-pressure: consumer stalls for 20 cycles after out_valid
        out_ready = 1'b0;
        accept(PT_B, KEY_B, 4, 2'b00, CT_B);
        wait_out("bp", 10);
        held = out;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_stable", out, held);
            check("bp_out_valid_held", 128'(out_valid), 128'd1);
            check("bp_in_ready_low", 128'(in_ready), 128'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        back_to_idle("bp");

        // Inputs change after acceptance; in-flight block must be unaffected
        accept(PT_B, KEY_B, 4, 2'b00, CT_B);
        in     = 128'($urandom) ^ {$urandom, $urandom, $urandom, $urandom};
        switch = 2'b10;
        wait_out("midrun", 10);
        back_to_idle("midrun");

        // Reset asserted while round 5 is being computed
        accept(PT_C, {KEY_C[255:128], 128'h0}, 4, 2'b00, CT_C128);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(out_valid), 128'd0);
        check("rst_mid_out", out, 128'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid_in_ready", 128'(in_ready), 128'd1);
        accept(PT_B, KEY_B, 4, 2'b00, CT_B);
        wait_out("post_reset_appB", 10);
        back_to_idle("post_reset_appB");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
